// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 key schedule.
//   NR / KW    : round count and key width
//   aes_word_t : one 32-bit schedule word, bit 0 is the MSB (FIPS-197 order)
//   ks_state_t : key-schedule FSM states
//   RCON       : round constants, indexed 1..NR
//   SBOX       : forward AES S-box, indexed by the input byte value
package aes_pkg;

  localparam int NR = 10;
  localparam int KW = 128;

  typedef logic [0:31] aes_word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } ks_state_t;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_sbox_word.sv
// Combinational SubWord: forward S-box applied to each byte of a word.
//   word   : input word, bit 0 is the MSB of byte 0
//   subbed : S-box substituted word, same byte order
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic [0:31] word,
  output logic [0:31] subbed
);

  always_comb begin
    subbed = {SBOX[word[0:7]], SBOX[word[8:15]], SBOX[word[16:23]], SBOX[word[24:31]]};
  end

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion with an 11-entry round-key bank.
// A loaded cipher key is expanded one round key per clock; once all keys are
// stored, any round key can be read by index (one-cycle registered read).
//
// Ports:
//   Clk, Reset_n : clock (rising edge), asynchronous active-low reset
//   key_in       : cipher key, bit 0 = MSB of byte 0
//   key_load     : load request
//   key_ready    : a key_load is taken on this edge when key_ready=1
//   busy         : expansion in progress
//   keys_valid   : all round keys stored
//   rk_index     : round key to read (0..10; larger values read as zero)
//   round_key    : registered bank[rk_index] of the previous cycle
//   state_dbg    : current FSM state (ks_state_t encoding)
//   zeroize      : only with KEYSCHED_ZEROIZE_EN defined; wipes all key
//                  material and returns to IDLE, overriding key_load
//
// Handshake: key_load is a single-cycle request with ready semantics; it is
// consumed on a rising edge only when key_ready=1, otherwise it is dropped
// (no queuing). key_ready may be high without a pending request.
module aes_key_schedule
  import aes_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic [0:KW-1] key_in,
  input  logic          key_load,
  output logic          key_ready,
  output logic          busy,
  output logic          keys_valid,
  input  logic [3:0]    rk_index,
  output logic [0:KW-1] round_key,
  output logic [1:0]    state_dbg
`ifdef KEYSCHED_ZEROIZE_EN
  ,
  input  logic          zeroize
`endif
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  ks_state_t     state, state_next;
  logic [3:0]    ctr;
  aes_word_t     w  [4];
  aes_word_t     nw [4];
  aes_word_t     rot_w3, sub_w3, temp;
  logic [7:0]    rcon;
  logic [0:KW-1] bank [NR+1];
  logic [0:KW-1] rd_sel;
  logic          zero_req;
  logic          load_take;

`ifdef KEYSCHED_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  assign load_take = key_load && (state != EXPAND) && !zero_req;

  assign key_ready  = (state != EXPAND);
  assign busy       = (state == EXPAND);
  assign keys_valid = (state == READY);
  assign state_dbg  = state;

  // RotWord is a left byte rotation of the last working word.
  assign rot_w3 = {w[3][8:31], w[3][0:7]};

  aes_sbox_word u_sbox (
    .word   (rot_w3),
    .subbed (sub_w3)
  );

  // One round of the word recurrence; ctr selects the round constant.
  always_comb begin
    rcon = 8'h00;
    for (int i = 1; i <= NR; i++) begin
      if (ctr == 4'(i)) rcon = RCON[i];
    end
    temp  = sub_w3 ^ {rcon, 24'h000000};
    nw[0] = w[0] ^ temp;
    nw[1] = w[1] ^ nw[0];
    nw[2] = w[2] ^ nw[1];
    nw[3] = w[3] ^ nw[2];
  end

  // Read mux; indices above NR fall through to zero.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i <= NR; i++) begin
      if (rk_index == 4'(i)) rd_sel = bank[i];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, READY: if (load_take) state_next = EXPAND;
      EXPAND:      if (ctr == LAST_RND) state_next = READY;
      default:     state_next = IDLE;
    endcase
    if (zero_req) state_next = IDLE;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ctr       <= '0;
      round_key <= '0;
      for (int i = 0; i < 4; i++)   w[i]    <= '0;
      for (int i = 0; i <= NR; i++) bank[i] <= '0;
    end else if (zero_req) begin
      ctr       <= '0;
      round_key <= '0;
      for (int i = 0; i < 4; i++)   w[i]    <= '0;
      for (int i = 0; i <= NR; i++) bank[i] <= '0;
    end else begin
      // A reload from READY blanks the output immediately, even though the
      // old bank contents are still present until overwritten.
      round_key <= (keys_valid && !load_take) ? rd_sel : '0;
      if (load_take) begin
        bank[0] <= key_in;
        w[0]    <= key_in[0:31];
        w[1]    <= key_in[32:63];
        w[2]    <= key_in[64:95];
        w[3]    <= key_in[96:127];
        ctr     <= 4'd1;
      end else if (state == EXPAND) begin
        for (int i = 1; i <= NR; i++) begin
          if (ctr == 4'(i)) bank[i] <= {nw[0], nw[1], nw[2], nw[3]};
        end
        for (int i = 0; i < 4; i++) w[i] <= nw[i];
        ctr <= ctr + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: a reference key expansion built from GF(2^8)
// arithmetic drives a per-cycle scoreboard; directed literal checks pin both
// the reference and the DUT to FIPS-197 vectors.
`timescale 1ns/1ps
module tb_aes_key_schedule;

  typedef logic [0:127] key_t;
  typedef key_t sched_t [11];

  // ---------------- clock / reset ----------------
  logic Clk     = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  key_t       key_in;
  logic       key_load;
  logic [3:0] rk_index;
  logic       zeroize;
  logic       key_ready, busy, keys_valid;
  key_t       round_key;
  logic [1:0] state_dbg;

  aes_key_schedule dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .key_in     (key_in),
    .key_load   (key_load),
    .key_ready  (key_ready),
    .busy       (busy),
    .keys_valid (keys_valid),
    .rk_index   (rk_index),
    .round_key  (round_key),
    .state_dbg  (state_dbg)
`ifdef KEYSCHED_ZEROIZE_EN
    ,
    .zeroize    (zeroize)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sbox_m [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box = affine transform of the multiplicative inverse.
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(b), 8'(c)) == 8'h01) inv = 8'(c);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_m[b] = s;
    end
  endtask

  // Textbook 44-word expansion over a flat word array.
  function automatic sched_t expand(input key_t k);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [127:0] kk;
    logic [7:0]   r;
    sched_t       s;
    kk = k;
    r  = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = kk[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {r, 24'h0};
        r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 11; j++) s[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return s;
  endfunction

  // Model state: expansion in flight, keys usable, cycles left, key set.
  logic   m_busy  = 1'b0;
  logic   m_valid = 1'b0;
  int     m_left  = 0;
  sched_t m_keys;
  logic [127:0] exp_q [$];

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_left  <= 0;
      exp_q.delete();
    end else begin
      exp_q.push_back((m_valid && !key_load && !zeroize && rk_index <= 4'd10)
                      ? m_keys[rk_index] : 128'h0);
      if (zeroize) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b0;
        m_left  <= 0;
      end else if (!m_busy && key_load) begin
        m_keys  <= expand(key_in);
        m_busy  <= 1'b1;
        m_valid <= 1'b0;
        m_left  <= 10;
      end else if (m_busy) begin
        if (m_left == 1) begin
          m_busy  <= 1'b0;
          m_valid <= 1'b1;
        end
        m_left <= m_left - 1;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge Clk) begin
    logic [127:0] e;
    if (!Reset_n) begin
      check("rst_key_ready", key_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_keys_valid", keys_valid, 0);
      check("rst_round_key", round_key, 0);
    end else begin
      check("key_ready", key_ready, !m_busy);
      check("busy", busy, m_busy);
      check("keys_valid", keys_valid, m_valid);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'h0;
      check("round_key", round_key, e);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge Clk);
    #1;
  endtask

  task automatic load_key(input key_t k);
    key_in   = k;
    key_load = 1'b1;
    cyc();
    key_load = 1'b0;
  endtask

  // Called just after the load edge: keys_valid must rise after the 10th edge.
  task automatic expect_latency(input string tag);
    for (int k = 0; k < 10; k++) begin
      check({tag, "_valid_low"}, keys_valid, 0);
      cyc();
    end
    check({tag, "_valid_high"}, keys_valid, 1);
  endtask

  function automatic key_t rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    key_t   ka, kb;
    sched_t sa;
    key_in   = '0;
    key_load = 1'b0;
    rk_index = 4'd0;
    zeroize  = 1'b0;
    build_sbox();

    // Pin the reference model to published values.
    check("model_sbox_00", sbox_m[0], 8'h63);
    check("model_sbox_53", sbox_m[8'h53], 8'hed);
    sa = expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("model_fips_rk1", sa[1], 128'ha0fafe1788542cb123a339392a6c7605);
    sa = expand(128'h000102030405060708090a0b0c0d0e0f);
    check("model_c1_rk10", sa[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    repeat (3) @(negedge Clk);
    #1 Reset_n = 1'b1;
    cyc();
    check("post_rst_ready", key_ready, 1);
    check("post_rst_round_key", round_key, 0);

    // FIPS-197 A.1 key, latency and two reads.
    load_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    expect_latency("fips");
    rk_index = 4'd1;
    cyc();
    check("fips_rk1", round_key, 128'ha0fafe1788542cb123a339392a6c7605);
    rk_index = 4'd10;
    cyc();
    check("fips_rk10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Reverse index sweep, one index per cycle.
    load_key(128'h000102030405060708090a0b0c0d0e0f);
    expect_latency("c1");
    for (int idx = 10; idx >= 0; idx--) begin
      rk_index = 4'(idx);
      cyc();
      if (idx == 10) check("sweep_first", round_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);
      if (idx == 0)  check("sweep_last", round_key, 128'h000102030405060708090a0b0c0d0e0f);
    end

    // key_load during EXPAND is dropped.
    ka = rand_key();
    kb = ~ka;
    load_key(ka);
    repeat (3) cyc();
    key_in   = kb;
    key_load = 1'b1;
    check("expand_key_ready", key_ready, 0);
    cyc();
    key_load = 1'b0;
    repeat (6) cyc();
    check("ignore_valid", keys_valid, 1);
    sa = expand(ka);
    rk_index = 4'd10;
    cyc();
    check("ignore_rk10", round_key, sa[10]);
    rk_index = 4'd5;
    cyc();
    check("ignore_rk5", round_key, sa[5]);

    // Asynchronous reset in the middle of an expansion.
    load_key(rand_key());
    repeat (5) cyc();
    Reset_n = 1'b0;
    #1;
    check("async_busy", busy, 0);
    check("async_valid", keys_valid, 0);
    check("async_ready", key_ready, 1);
    check("async_round_key", round_key, 0);
    cyc();
    Reset_n  = 1'b1;
    cyc();
    rk_index = 4'd0;
    cyc();
    check("after_rst_rk0", round_key, 0);
    check("after_rst_ready", key_ready, 1);

    // Out-of-range indices, then reload from READY.
    ka = rand_key();
    load_key(ka);
    expect_latency("oor");
    sa = expand(ka);
    rk_index = 4'd3;
    cyc();
    check("oor_rk3", round_key, sa[3]);
    rk_index = 4'd11;
    cyc();
    check("oor_idx11", round_key, 0);
    rk_index = 4'd15;
    cyc();
    check("oor_idx15", round_key, 0);
    rk_index = 4'd2;
    cyc();
    kb = rand_key();
    load_key(kb);
    check("reload_round_key_zero", round_key, 0);
    expect_latency("reload");
    sa = expand(kb);
    cyc();
    check("reload_rk2", round_key, sa[2]);

    // Reset while a nonzero key is being presented.
    Reset_n = 1'b0;
    #1;
    check("rst_ready_rk", round_key, 0);
    check("rst_ready_valid", keys_valid, 0);
    cyc();
    Reset_n = 1'b1;
    cyc();

    // key_load held high: reload on every READY entry.
    key_load = 1'b1;
    for (int c = 0; c < 30; c++) begin
      key_in   = rand_key();
      rk_index = 4'($urandom_range(0, 15));
      cyc();
    end
    key_load = 1'b0;
    repeat (12) cyc();

    // Randomized traffic.
    for (int n = 0; n < 6; n++) begin
      load_key(rand_key());
      for (int c = 0; c < int'($urandom_range(10, 24)); c++) begin
        rk_index = 4'($urandom_range(0, 15));
        key_load = ($urandom_range(0, 9) == 0);
        key_in   = rand_key();
        cyc();
      end
      key_load = 1'b0;
      repeat (12) cyc();
    end

`ifdef KEYSCHED_ZEROIZE_EN
    // Zeroize wins over a simultaneous load.
    ka = rand_key();
    load_key(ka);
    repeat (10) cyc();
    rk_index = 4'd4;
    cyc();
    sa = expand(ka);
    check("zz_pre_rk4", round_key, sa[4]);
    zeroize  = 1'b1;
    key_load = 1'b1;
    key_in   = rand_key();
    cyc();
    zeroize  = 1'b0;
    key_load = 1'b0;
    check("zz_valid", keys_valid, 0);
    check("zz_round_key", round_key, 0);
    check("zz_busy", busy, 0);
    check("zz_ready", key_ready, 1);
    cyc();
    check("zz_still_idle", busy, 0);
    check("zz_round_key2", round_key, 0);
`endif

    repeat (2) cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
- Iterative AES-128 key expansion that produces the `round_key` consumed by each decryption round stage.
- Loads a 128-bit cipher key and computes all 11 round keys, one per clock.
- Stores the keys in a register bank and serves any round key by index, so decryption rounds can fetch keys in reverse order (10 down to 0).
- Sits directly upstream of the decryption round stages.

Parameters:
- NR, 10, number of AES-128 rounds. Fixed; the bank holds NR+1 keys.
- KW, 128, key and round-key width.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- key_in  in  [0:127]  cipher key; bit 0 is the MSB of byte 0 (FIPS-197 byte order).
- key_load  in  1  request to load `key_in`; accepted only when `key_ready`=1.
- key_ready  out  1  block can accept a new key.
- busy  out  1  expansion in progress.
- keys_valid  out  1  all 11 round keys are stored and valid.
- rk_index  in  [3:0]  round-key index to read, 0..10.
- round_key  out  [0:127]  registered round key selected by `rk_index`.
- zeroize  in  1  present only when `KEYSCHED_ZEROIZE_EN` is defined.

Behaviour:
- Reset (async, Reset_n=0) clears:
  - FSM to IDLE, round counter to 0.
  - All 11 bank entries to 0.
  - Outputs: `round_key`=0, `keys_valid`=0, `busy`=0, `key_ready`=1.
- FSM has three states: IDLE, EXPAND, READY.
- IDLE: `key_ready`=1. When `key_load`=1, the edge does the following:
  - bank[0] <= `key_in`
  - working words w0..w3 <= `key_in`
  - counter <= 1
  - go to EXPAND.
- EXPAND (`busy`=1, `key_ready`=0) computes one key per cycle for i = counter:
  - temp = SubWord(RotWord(w3)) xor {Rcon[i],24'h0}
  - w0' = w0^temp; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'
  - bank[i] <= {w0',w1',w2',w3'}; counter increments.
  - After i=10 is written, go to READY.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36. RotWord is a left byte rotation; SubWord is the forward S-box applied to each byte.
- READY: `keys_valid`=1, `key_ready`=1.
- Latency: `key_load` accepted at edge T gives `keys_valid`=1 after edge T+10 (10 EXPAND cycles).
- Read path: `round_key` <= bank[`rk_index`] on every edge while `keys_valid`=1. Data appears one cycle after the index.
  - `round_key` <= 0 when `keys_valid`=0.
  - `round_key` <= 0 when `rk_index` > 10.
- Boundary conditions:
  - `key_load` during EXPAND is ignored; no queuing.
  - `key_load` in READY restarts the load exactly as in IDLE. `keys_valid` drops at that edge; old bank[1..10] contents stay readable internally but `round_key` is forced to 0 until the new expansion completes.
  - `key_load` held high continuously: reloads on every READY entry.
  - Reset asserted mid-EXPAND: immediate clear; the partial schedule is discarded.
  - `rk_index` changing every cycle: each cycle returns the key for the previous cycle's index, with no bubbles.

Optional Feature:
- Macro `KEYSCHED_ZEROIZE_EN`.
- When defined: `zeroize`=1 in any state, at the next edge:
  - clears all bank entries, w0..w3, and `round_key`
  - forces IDLE with `keys_valid`=0.
  - `zeroize` has priority over a simultaneous `key_load`.
- When undefined: the port is absent, and keys persist until reset or reload.

Decomposition:
- Package `aes_pkg`:
  - FSM state enum `ks_state_t` {IDLE, EXPAND, READY}
  - Rcon constant array [1:10]
  - NR and KW constants
  - `aes_word_t` = logic [0:31].
- One combinational sub-module, `aes_sbox_word`: four forward S-box lookups on a 32-bit word. Instantiated once on RotWord(w3).

Test Plan:
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, load then `rk_index`=1 -> `round_key`=a0fafe1788542cb123a339392a6c7605; `rk_index`=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6; `keys_valid` rises exactly 10 cycles after the load edge.
- Key 000102030405060708090a0b0c0d0e0f, sweep `rk_index` 10..0 one per cycle -> first output 13111d7fe3944a17f307a78b4d2b30c5, last 000102...0f; each value lags its index by 1 cycle.
- Pulse `key_load` with a different key at EXPAND cycle 4 -> ignored, `key_ready`=0, bank matches the first key.
- Deassert Reset_n at EXPAND cycle 6 -> `busy`/`keys_valid`/`round_key`=0 asynchronously; after release, `key_ready`=1 and `rk_index`=0 yields 0.
- READY, `rk_index`=11 and 15 -> `round_key`=0. `key_load` in READY -> `keys_valid`=0 next cycle, new keys valid 10 cycles later.
- (`KEYSCHED_ZEROIZE_EN`) READY, `zeroize` with `key_load` same cycle -> IDLE, `keys_valid`=0, `round_key`=0, load not taken.
